// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: stage-0 counters and pixel request for a
// pixel source, plus a delay line that lines the syncs up with the returned colour.
module vga_timing_gen #(
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_PW   = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_PW   = 2,
    parameter int V_BP   = 33,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int CW     = 3,
    parameter int PIPE   = 0,
    parameter int CNT_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             en,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             px_req,
    input  logic [CW-1:0]    px_r,
    input  logic [CW-1:0]    px_g,
    input  logic [CW-1:0]    px_b,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CW-1:0]    red,
    output logic [CW-1:0]    green,
    output logic [CW-1:0]    blue,
    output logic             sof,
    output logic             eof
);

    localparam int H_TOT = H_RES + H_FP + H_PW + H_BP;
    localparam int V_TOT = V_RES + V_FP + V_PW + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_RES + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_RES + H_FP + H_PW);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_RES + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_RES + V_FP + V_PW);

    // Delay-line entries carry active flags; polarity is applied only at the output.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic sof;
    } stage_t;

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    stage_t           stage0;
    stage_t           stage_last;

    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic [CW-1:0]    red_q, red_d;
    logic [CW-1:0]    green_q, green_d;
    logic [CW-1:0]    blue_q, blue_d;
    logic             sof_q, sof_d;

    // en=0 parks the raster at (0,0) on every clk, independent of ce.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (!en) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        stage0     = '0;
        stage0.de  = en && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        stage0.hs  = en && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        stage0.vs  = en && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        stage0.sof = stage0.de && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    assign px_x   = h_cnt_q;
    assign px_y   = v_cnt_q;
    assign px_req = stage0.de;
    assign eof    = en && ce && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    generate
        if (PIPE == 0) begin : g_nopipe
            assign stage_last = stage0;
        end else begin : g_pipe
            stage_t [PIPE-1:0] dly_q, dly_d;

            always_comb begin
                dly_d = dly_q;
                if (ce) begin
                    dly_d[0] = stage0;
                    for (int i = 1; i < PIPE; i++) begin
                        dly_d[i] = dly_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign stage_last = dly_q[PIPE-1];
        end
    endgenerate

    // sof is re-evaluated every clk so it stays a single-clk pulse when ce is sparse.
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        sof_d   = 1'b0;
        if (ce) begin
            hs_d    = stage_last.hs ? HS_POL : ~HS_POL;
            vs_d    = stage_last.vs ? VS_POL : ~VS_POL;
            de_d    = stage_last.de;
            red_d   = stage_last.de ? px_r : '0;
            green_d = stage_last.de ? px_g : '0;
            blue_d  = stage_last.de ? px_b : '0;
            sof_d   = stage_last.sof;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            de_q    <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            sof_q   <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            sof_q   <= sof_d;
        end
    end

    assign hs    = hs_q;
    assign vs    = vs_q;
    assign de    = de_q;
    assign red   = red_q;
    assign green = green_q;
    assign blue  = blue_q;
    assign sof   = sof_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small 14x7 raster with a 3-tick pixel source;
// stimulus pushes expected outputs, a negedge monitor pops and compares them.
module tb_vga_timing_gen;

    localparam int PIPE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        en;
    logic [11:0] px_x;
    logic [11:0] px_y;
    logic        px_req;
    logic [2:0]  px_r, px_g, px_b;
    logic        hs, vs, de;
    logic [2:0]  red, green, blue;
    logic        sof, eof;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_RES(8), .H_FP(2), .H_PW(3), .H_BP(1),
        .V_RES(4), .V_FP(1), .V_PW(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(3), .PIPE(PIPE), .CNT_W(12)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .en(en),
        .px_x(px_x), .px_y(px_y), .px_req(px_req),
        .px_r(px_r), .px_g(px_g), .px_b(px_b),
        .hs(hs), .vs(vs), .de(de),
        .red(red), .green(green), .blue(blue),
        .sof(sof), .eof(eof)
    );

    // Pixel source with a 3-tick latency, encoding the requested coordinate into the colour.
    logic [7:0] src1, src2, src3;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src1 <= '0;
            src2 <= '0;
            src3 <= '0;
        end else if (ce) begin
            src1 <= {px_x[2:0], px_y[2:0], px_x[3], px_y[3]};
            src2 <= src1;
            src3 <= src2;
        end
    end
    assign px_r = src3[7:5];
    assign px_g = src3[4:2];
    assign px_b = {1'b0, src3[1:0]};

    typedef struct {
        bit hs, vs, de, sof;
        int x, y;
    } mstage_t;

    typedef struct {
        int x, y, r, g, b;
        bit req, eof, hs, vs, de, sof;
    } exp_t;

    exp_t    exp_q[$];
    mstage_t mdly[$];
    int      mh, mv;
    bit      o_hs_act, o_vs_act, o_de, o_sof;
    int      o_r, o_g, o_b;

    // Hand-derived raster: active h 0..7, hs h 10..12, line 14; active v 0..3, vs v 5, frame 7 lines.
    function automatic mstage_t stage_now();
        mstage_t s;
        s.de  = en && mh < 8 && mv < 4;
        s.hs  = en && mh >= 10 && mh <= 12;
        s.vs  = en && mv == 5;
        s.sof = s.de && mh == 0 && mv == 0;
        s.x   = mh;
        s.y   = mv;
        return s;
    endfunction

    task automatic resetModel();
        mstage_t idle;
        idle = '{hs: 0, vs: 0, de: 0, sof: 0, x: 0, y: 0};
        mh = 0;
        mv = 0;
        mdly.delete();
        for (int i = 0; i < PIPE; i++) mdly.push_back(idle);
        o_hs_act = 0; o_vs_act = 0; o_de = 0; o_sof = 0;
        o_r = 0; o_g = 0; o_b = 0;
    endtask

    task automatic modelEdge();
        mstage_t s0, last;
        s0 = stage_now();
        o_sof = 0;
        if (ce) begin
            last = mdly.pop_front();
            mdly.push_back(s0);
            o_hs_act = last.hs;
            o_vs_act = last.vs;
            o_de     = last.de;
            o_sof    = last.sof;
            o_r      = last.de ? (last.x & 7) : 0;
            o_g      = last.de ? (last.y & 7) : 0;
            o_b      = last.de ? ((((last.x >> 3) & 1) << 1) | ((last.y >> 3) & 1)) : 0;
        end
        if (!en) begin
            mh = 0;
            mv = 0;
        end else if (ce) begin
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
    endtask

    task automatic pushExpect();
        exp_t e;
        e.x   = mh;
        e.y   = mv;
        e.req = en && mh < 8 && mv < 4;
        e.eof = en && ce && mh == 13 && mv == 6;
        e.hs  = o_hs_act;
        e.vs  = !o_vs_act;
        e.de  = o_de;
        e.sof = o_sof;
        e.r   = o_r;
        e.g   = o_g;
        e.b   = o_b;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit ce_i, input bit en_i);
        @(posedge clk);
        #1;
        modelEdge();
        ce = ce_i;
        en = en_i;
        pushExpect();
    endtask

    // Reset is raised and dropped between two clk edges to show it acts without an edge.
    task automatic resetPulse();
        @(posedge clk);
        #1;
        modelEdge();
        rst = 1'b1;
        resetModel();
        pushExpect();
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("px_x",   32'(px_x),   32'(e.x));
            checkOutput("px_y",   32'(px_y),   32'(e.y));
            checkOutput("px_req", 32'(px_req), 32'(e.req));
            checkOutput("eof",    32'(eof),    32'(e.eof));
            checkOutput("hs",     32'(hs),     32'(e.hs));
            checkOutput("vs",     32'(vs),     32'(e.vs));
            checkOutput("de",     32'(de),     32'(e.de));
            checkOutput("sof",    32'(sof),    32'(e.sof));
            checkOutput("red",    32'(red),    32'(e.r));
            checkOutput("green",  32'(green),  32'(e.g));
            checkOutput("blue",   32'(blue),   32'(e.b));
        end
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        resetModel();
        pushExpect();
        @(negedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);

        $display("[TB] free run, ce every clk");
        for (int i = 0; i < 230; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] ce one clk in four");
        for (int i = 0; i < 420; i++) applyStimulus((i % 4) == 0, 1'b1);

        $display("[TB] en dropped mid-frame");
        for (int i = 0; i < 200; i++) begin
            if (mh == 3 && mv == 2) break;
            applyStimulus(1'b1, 1'b1);
        end
        for (int i = 0; i < 50; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 120; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] reset pulse mid-line");
        for (int i = 0; i < 200; i++) begin
            if (mh == 5 && mv == 1) break;
            applyStimulus(1'b1, 1'b1);
        end
        resetPulse();
        for (int i = 0; i < 150; i++) applyStimulus(1'b1, 1'b1);

        $display("[TB] ce alternating with en toggles");
        for (int i = 0; i < 60; i++) applyStimulus(i[0], 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator with a pixel-source request port and a latency-matched output stage. It replaces the fixed 640x480@60 generator in the vumeter display path. It drives counters and a pixel request for a pixel source (bar renderer, frame buffer) that has a configurable pipeline latency. It then delays hs/vs/de by that latency so the colour outputs line up with the syncs at the connector.

## Interface
- H_RES, 640: active pixels per line
- H_FP, 16: horizontal front porch, ticks
- H_PW, 96: horizontal sync width, ticks
- H_BP, 48: horizontal back porch, ticks
- V_RES, 480: active lines per frame
- V_FP, 10: vertical front porch, lines
- V_PW, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- HS_POL, 0: hs active level (0 = active-low)
- VS_POL, 0: vs active level
- CW, 3: colour bits per channel (red, green, blue all CW)
- PIPE, 0: pixel-source latency in ticks, 0..7
- CNT_W, 12: counter width; H_RES+H_FP+H_PW+H_BP and the vertical total must be < 2^CNT_W
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- ce  in  1  pixel-clock enable; one "tick" = clk edge with ce=1
- en  in  1  run enable
- px_x  out  CNT_W  current horizontal counter (stage 0)
- px_y  out  CNT_W  current vertical counter (stage 0)
- px_req  out  1  stage-0 active-area flag
- px_r, px_g, px_b  in  CW each  source colour, returned PIPE ticks after px_req
- hs, vs  out  1  syncs, delayed PIPE+1 ticks
- de  out  1  data enable, delayed PIPE+1 ticks
- red, green, blue  out  CW each  output colour, zero outside de
- sof  out  1  start-of-frame pulse, aligned with output pixel (0,0)
- eof  out  1  stage-0 last-position-of-frame pulse

## Operation
- H_TOT = H_RES+H_FP+H_PW+H_BP; V_TOT likewise.
- Horizontal order is active, FP, sync, BP. Vertical order is the same.
- Counter h_cnt runs 0..H_TOT-1 and v_cnt runs 0..V_TOT-1, so coordinate = counter.
- Counters advance only on ticks with en=1.
  - At h_cnt = H_TOT-1, h_cnt wraps to 0 and v_cnt increments.
  - At h_cnt = H_TOT-1 and v_cnt = V_TOT-1, both wrap to 0.
- Stage-0 signals are combinational from the counter registers:
  - de0 = en & h_cnt<H_RES & v_cnt<V_RES.
  - hs0 is active for H_RES+H_FP <= h_cnt < H_RES+H_FP+H_PW.
  - vs0 is active for whole lines V_RES+V_FP <= v_cnt < V_RES+V_FP+V_PW.
  - Both syncs are inactive when en=0.
- px_x = h_cnt, px_y = v_cnt, px_req = de0.
- eof = en & ce at the final frame position. It is one clk wide.
- Delay line: hs0/vs0/de0/sof0 shift through PIPE registers, advancing on ticks only. sof0 = de0 at (0,0).
- Output registers load on a tick from the last delay stage:
  - Syncs are driven at the active level given by HS_POL/VS_POL.
  - red/green/blue <= stage-PIPE de ? px_r/g/b : 0.
  - With PIPE=0, the source is combinational on px_x/px_y.
- sof is high for exactly one clk after the tick that loads pixel (0,0) into the output.
- en=0 holds the counters at (0,0) synchronously, checked every clk regardless of ce.
  - The delay line keeps shifting idle values on ticks.
  - On the first tick with en=1, stage 0 presents (0,0). A frame always starts at (0,0).
- ce=0 freezes all counter and delay state. Outputs hold their values, except sof and eof, which return to 0.

## Timing
- Reset (async) values:
  - h_cnt = v_cnt = 0.
  - Delay stages: idle values (de 0, syncs inactive).
  - hs = ~HS_POL, vs = ~VS_POL, de = 0, red = green = blue = 0, sof = 0, eof = 0.
- Latency: px_req to de/hs/vs/colour is PIPE+1 ticks. Sync-to-de relationships at the output are identical to stage 0.
- hs transitions occur on ticks. vs transitions occur only on ticks where h_cnt wraps to 0.
- Default timing gives 800 ticks/line and 420000 ticks/frame. hs is active for 96 ticks per line; vs is active for 1600 ticks per frame.
- rst mid-frame: everything returns to reset values immediately. The next frame starts at (0,0) on the first tick after release if en=1.
- Simultaneous h wrap and v wrap: a single tick performs both. eof fires on that tick.

## Test plan
- Reset, default params, ce=1, en=1:
  - hs first active at tick 656+1 (PIPE=0), lasting 96 ticks.
  - Line period 800, frame period 420000.
  - vs active for lines 490..491.
  - de high 640 ticks per active line and 307200 ticks per frame.
- PIPE=3, source = 3-stage register of {px_x[2:0], px_y[2:0], px_x[3], px_y[3]}: red equals x[2:0] of the pixel whose de is high at the output. sof coincides with the first de cycle of each frame.
- ce asserted one clk in four: all periods scale to 3200 clk/line. sof and eof are single-clk pulses. Outputs are stable between ticks.
- Custom H_RES=8, H_FP=2, H_PW=3, H_BP=1, V_RES=4, V_FP=1, V_PW=1, V_BP=1, HS_POL=1:
  - hs high at h 10..12.
  - Frame period 14*7 = 98 ticks.
  - eof at (13,6).
- en dropped at (100,200) for 50 clk, then raised: counters read (0,0) during low, de and syncs inactive after PIPE+1 ticks. The restarted frame begins at (0,0).
- rst pulsed mid-line at (300,100) for part of one clk cycle: outputs go to reset values immediately without waiting for a clk edge. The next sof occurs PIPE+1 ticks after release.
